// File: rtl/mc_pkg.sv
// Shared constants for the multicycle control FSM: opcodes, functs, ALU codes, state encodings.
// The JAL state exists only when MC_JAL_EN is defined.
package mc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
`ifdef MC_JAL_EN
    , S_JAL  = 4'd11
`endif
  } state_e;

  // ALU operation class selected by the current state
  typedef enum logic [1:0] {
    ACLS_ADD   = 2'd0,
    ACLS_RTYPE = 2'd1,
    ACLS_ITYPE = 2'd2,
    ACLS_SUB   = 2'd3
  } alu_cls_e;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle FSM (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if
  import mc_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
);
  logic [OP_W-1:0]       opcode;
  logic [FUNCT_W-1:0]    funct;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  ir_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  i_or_d;
  logic                  alu_src_a;
  logic                  reg_write;
  logic                  branch;
  logic                  branch_ne;
  logic                  imm_zext;
  logic [1:0]            pc_src;
  logic [1:0]            alu_src_b;
  logic [1:0]            reg_dst;
  logic [1:0]            mem_to_reg;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  illegal;
  logic                  timeout;
  logic [STATE_W-1:0]    state_o;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a, reg_write,
           branch, branch_ne, imm_zext, pc_src, alu_src_b, reg_dst, mem_to_reg,
           alu_control, illegal, timeout, state_o
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a, reg_write,
           branch, branch_ne, imm_zext, pc_src, alu_src_b, reg_dst, mem_to_reg,
           alu_control, illegal, timeout, state_o
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// Maps the state's ALU class plus opcode/funct to a 3-bit ALU code and flags unknown R-type functs.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  alu_cls_e           cls_i,
  input  logic [OP_W-1:0]    opcode_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [ALU_W-1:0]   alu_code_o,
  output logic               funct_illegal_o
);

  always_comb begin
    alu_code_o      = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (cls_i)
      ACLS_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_code_o = ALU_ADD;
          FN_SUB:  alu_code_o = ALU_SUB;
          FN_AND:  alu_code_o = ALU_AND;
          FN_OR:   alu_code_o = ALU_OR;
          FN_SLT:  alu_code_o = ALU_SLT;
          default: funct_illegal_o = 1'b1;
        endcase
      end
      ACLS_ITYPE: begin
        case (opcode_i)
          OP_ANDI: alu_code_o = ALU_AND;
          OP_ORI:  alu_code_o = ALU_OR;
          OP_SLTI: alu_code_o = ALU_SLT;
          default: alu_code_o = ALU_ADD;
        endcase
      end
      ACLS_SUB: alu_code_o = ALU_SUB;
      default:  alu_code_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for a multicycle MIPS-style datapath with a memory-wait timeout.
// Define MC_JAL_EN to add the single-cycle JAL state (opcode 0x03).
module multicycle_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned TO_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  // Timeout fires on the (2^TO_W-1)-th consecutive not-ready wait cycle
  localparam int unsigned TO_LAST = (1 << TO_W) - 2;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  alu_cls_e          alu_cls;
  logic [ALU_W-1:0]  alu_code;
  logic              funct_ill;
  logic              waiting;

  logic pc_write_c, ir_write_c, mem_read_c, mem_write_c, i_or_d_c, alu_src_a_c;
  logic reg_write_c, branch_c, branch_ne_c, imm_zext_c, illegal_c, timeout_c;
  logic [1:0] pc_src_c, alu_src_b_c, reg_dst_c, mem_to_reg_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU class depends only on the state register
  always_comb begin
    alu_cls = ACLS_ADD;
    case (state_q)
      S_EXEC_R: alu_cls = ACLS_RTYPE;
      S_EXEC_I: alu_cls = ACLS_ITYPE;
      S_BRANCH: alu_cls = ACLS_SUB;
      default:  alu_cls = ACLS_ADD;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .cls_i           (alu_cls),
    .opcode_i        (bus.opcode),
    .funct_i         (bus.funct),
    .alu_code_o      (alu_code),
    .funct_illegal_o (funct_ill)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    waiting      = 1'b0;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    i_or_d_c     = 1'b0;
    alu_src_a_c  = 1'b0;
    reg_write_c  = 1'b0;
    branch_c     = 1'b0;
    branch_ne_c  = 1'b0;
    imm_zext_c   = 1'b0;
    illegal_c    = 1'b0;
    timeout_c    = 1'b0;
    pc_src_c     = 2'd0;
    alu_src_b_c  = 2'd0;
    reg_dst_c    = 2'd0;
    mem_to_reg_c = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'd1;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'd3;
        case (bus.opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
`ifdef MC_JAL_EN
          OP_JAL:                            state_d = S_JAL;
`endif
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        state_d     = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
        else               waiting = 1'b1;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 2'd1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
        else               waiting = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        if (funct_ill) begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        imm_zext_c  = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = (bus.opcode == OP_RTYPE) ? 2'd1 : 2'd0;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        pc_src_c    = 2'd1;
        branch_c    = 1'b1;
        branch_ne_c = (bus.opcode == OP_BNE);
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = 2'd2;
        state_d    = S_FETCH;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        pc_write_c   = 1'b1;
        pc_src_c     = 2'd2;
        reg_write_c  = 1'b1;
        reg_dst_c    = 2'd2;
        mem_to_reg_c = 2'd2;
        state_d      = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    // Wait-state watchdog: abort the access and refetch
    if (waiting) begin
      if (cnt_q == TO_W'(TO_LAST)) begin
        timeout_c   = 1'b1;
        mem_write_c = 1'b0;
        state_d     = S_FETCH;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.ir_write    = ir_write_c;
  assign bus.mem_read    = mem_read_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.i_or_d      = i_or_d_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.reg_write   = reg_write_c;
  assign bus.branch      = branch_c;
  assign bus.branch_ne   = branch_ne_c;
  assign bus.imm_zext    = imm_zext_c;
  assign bus.pc_src      = pc_src_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.reg_dst     = reg_dst_c;
  assign bus.mem_to_reg  = mem_to_reg_c;
  assign bus.alu_control = ALU_CTRL_W'(alu_code);
  assign bus.illegal     = illegal_c;
  assign bus.timeout     = timeout_c;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: expected outputs queued per cycle, compared at the falling edge.
// Instance A uses default TO_W, instance B uses TO_W=2 for the watchdog; MC_JAL_EN selects the JAL branch.
module tb_multicycle_ctrl_fsm;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.ALU_CTRL_W(3)) ifa ();
  multicycle_ctrl_fsm_if #(.ALU_CTRL_W(3)) ifb ();

  multicycle_ctrl_fsm #(.ALU_CTRL_W(3), .TO_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
  multicycle_ctrl_fsm #(.ALU_CTRL_W(3), .TO_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

  typedef enum int {
    F_STATE, F_PCW, F_IRW, F_MRD, F_MWR, F_IORD, F_SRCA, F_SRCB, F_REGW,
    F_REGDST, F_M2R, F_PCSRC, F_BR, F_BNE, F_ZEXT, F_ALU, F_ILL, F_TO
  } field_e;

  typedef struct {
    string      tag;
    field_e     f;
    logic [7:0] v;
    bit         b;
  } item_t;

  item_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] probe(field_e f, bit b);
    case (f)
      F_STATE:  return 8'(b ? ifb.state_o     : ifa.state_o);
      F_PCW:    return 8'(b ? ifb.pc_write    : ifa.pc_write);
      F_IRW:    return 8'(b ? ifb.ir_write    : ifa.ir_write);
      F_MRD:    return 8'(b ? ifb.mem_read    : ifa.mem_read);
      F_MWR:    return 8'(b ? ifb.mem_write   : ifa.mem_write);
      F_IORD:   return 8'(b ? ifb.i_or_d      : ifa.i_or_d);
      F_SRCA:   return 8'(b ? ifb.alu_src_a   : ifa.alu_src_a);
      F_SRCB:   return 8'(b ? ifb.alu_src_b   : ifa.alu_src_b);
      F_REGW:   return 8'(b ? ifb.reg_write   : ifa.reg_write);
      F_REGDST: return 8'(b ? ifb.reg_dst     : ifa.reg_dst);
      F_M2R:    return 8'(b ? ifb.mem_to_reg  : ifa.mem_to_reg);
      F_PCSRC:  return 8'(b ? ifb.pc_src      : ifa.pc_src);
      F_BR:     return 8'(b ? ifb.branch      : ifa.branch);
      F_BNE:    return 8'(b ? ifb.branch_ne   : ifa.branch_ne);
      F_ZEXT:   return 8'(b ? ifb.imm_zext    : ifa.imm_zext);
      F_ALU:    return 8'(b ? ifb.alu_control : ifa.alu_control);
      F_ILL:    return 8'(b ? ifb.illegal     : ifa.illegal);
      default:  return 8'(b ? ifb.timeout     : ifa.timeout);
    endcase
  endfunction

  task automatic ea(string tag, field_e f, int unsigned v);
    item_t it;
    it = '{tag, f, 8'(v), 1'b0};
    sb.push_back(it);
  endtask

  task automatic eb(string tag, field_e f, int unsigned v);
    item_t it;
    it = '{tag, f, 8'(v), 1'b1};
    sb.push_back(it);
  endtask

  task automatic check();
    item_t      it;
    logic [7:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = probe(it.f, it.b);
      n_cmp++;
      assert (obs === it.v) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(logic [5:0] op, logic [5:0] fn, logic rdy);
    ifa.opcode    = op;
    ifa.funct     = fn;
    ifa.mem_ready = rdy;
  endtask

  initial begin
    rst_n = 1'b1;
    drive_a(OP_RTYPE, FN_ADD, 1'b0);
    ifb.opcode = OP_RTYPE; ifb.funct = FN_ADD; ifb.mem_ready = 1'b0;
    #2 rst_n = 1'b0;

    ea("rst_state", F_STATE, S_FETCH); ea("rst_ill", F_ILL, 0); ea("rst_to", F_TO, 0);
    ea("rst_mwr", F_MWR, 0); eb("rst_b_to", F_TO, 0);
    check();

    // Release; B waits with mem_ready low to exercise the 3-cycle watchdog
    tick(); rst_n = 1'b1;
    ea("rel_state", F_STATE, S_FETCH); ea("rel_mrd", F_MRD, 1); ea("rel_pcw", F_PCW, 0);
    ea("rel_irw", F_IRW, 0); ea("rel_mwr", F_MWR, 0); ea("rel_regw", F_REGW, 0);
    eb("to_w1", F_TO, 0); eb("to_w1_irw", F_IRW, 0);
    check();
    tick();
    eb("to_w2", F_TO, 0); eb("to_w2_irw", F_IRW, 0); eb("to_w2_st", F_STATE, S_FETCH);
    check();
    tick(); drive_a(OP_RTYPE, FN_ADD, 1'b1);
    eb("to_w3", F_TO, 1); eb("to_w3_irw", F_IRW, 0); eb("to_w3_st", F_STATE, S_FETCH);
    ea("f_irw", F_IRW, 1); ea("f_pcw", F_PCW, 1); ea("f_srcb", F_SRCB, 1); ea("f_alu", F_ALU, 3'b010);
    check();
    tick();
    eb("to_w4", F_TO, 0); eb("to_w4_st", F_STATE, S_FETCH); eb("to_w4_irw", F_IRW, 0);
    ea("add_dec", F_STATE, S_DECODE); ea("dec_srcb", F_SRCB, 3); ea("dec_mrd", F_MRD, 0);
    ea("dec_ill", F_ILL, 0);
    check();
    tick();
    ea("add_exec", F_STATE, S_EXEC_R); ea("add_alu", F_ALU, 3'b010); ea("add_regw0", F_REGW, 0);
    ea("add_srca", F_SRCA, 1);
    check();
    tick();
    ea("add_wb", F_STATE, S_ALUWB); ea("add_regw", F_REGW, 1); ea("add_regdst", F_REGDST, 1);
    ea("add_m2r", F_M2R, 0);
    check();

    // LW with three not-ready cycles in MEMRD
    tick(); drive_a(OP_LW, 6'h00, 1'b1);
    ea("lw_fetch", F_STATE, S_FETCH); ea("lw_fetch_regw", F_REGW, 0);
    check();
    tick();
    ea("lw_dec", F_STATE, S_DECODE);
    check();
    tick(); ifa.mem_ready = 1'b0;
    ea("lw_adr", F_STATE, S_MEMADR); ea("lw_adr_srcb", F_SRCB, 2); ea("lw_adr_srca", F_SRCA, 1);
    check();
    for (int i = 0; i < 3; i++) begin
      tick();
      ea("lw_rd_wait", F_STATE, S_MEMRD); ea("lw_rd_iord", F_IORD, 1); ea("lw_rd_mrd", F_MRD, 1);
      ea("lw_rd_regw", F_REGW, 0);
      check();
    end
    tick(); ifa.mem_ready = 1'b1;
    ea("lw_rd_last", F_STATE, S_MEMRD); ea("lw_rd_to", F_TO, 0);
    check();
    tick();
    ea("lw_wb", F_STATE, S_MEMWB); ea("lw_wb_regw", F_REGW, 1); ea("lw_wb_m2r", F_M2R, 1);
    ea("lw_wb_regdst", F_REGDST, 0);
    check();

    // BNE
    tick(); drive_a(OP_BNE, 6'h00, 1'b1);
    ea("bne_fetch", F_STATE, S_FETCH);
    check();
    tick();
    ea("bne_dec", F_STATE, S_DECODE);
    check();
    tick();
    ea("bne_st", F_STATE, S_BRANCH); ea("bne_br", F_BR, 1); ea("bne_ne", F_BNE, 1);
    ea("bne_alu", F_ALU, 3'b110); ea("bne_pcsrc", F_PCSRC, 1);
    check();

    // Unknown opcode 0x3F
    tick(); drive_a(6'h3F, 6'h00, 1'b1);
    ea("bad_fetch", F_STATE, S_FETCH);
    check();
    tick();
    ea("bad_dec", F_STATE, S_DECODE); ea("bad_ill", F_ILL, 1);
    check();

    // Opcode 0x03
    tick(); drive_a(OP_JAL, 6'h00, 1'b1);
    ea("jal_fetch", F_STATE, S_FETCH); ea("jal_fetch_ill", F_ILL, 0);
    check();
    tick();
`ifdef MC_JAL_EN
    ea("jal_dec_ill", F_ILL, 0);
    check();
    tick();
    ea("jal_st", F_STATE, S_JAL); ea("jal_regdst", F_REGDST, 2); ea("jal_m2r", F_M2R, 2);
    ea("jal_pcsrc", F_PCSRC, 2); ea("jal_pcw", F_PCW, 1); ea("jal_regw", F_REGW, 1);
    check();
`else
    ea("jal_dec_ill", F_ILL, 1);
    check();
`endif
    tick(); drive_a(OP_ORI, 6'h00, 1'b1);
    ea("ori_fetch", F_STATE, S_FETCH);
    check();

    // ORI: zero-extended immediate, write to rt
    tick();
    ea("ori_dec", F_STATE, S_DECODE);
    check();
    tick();
    ea("ori_exec", F_STATE, S_EXEC_I); ea("ori_alu", F_ALU, 3'b001); ea("ori_zext", F_ZEXT, 1);
    ea("ori_srcb", F_SRCB, 2);
    check();
    tick();
    ea("ori_wb", F_STATE, S_ALUWB); ea("ori_regw", F_REGW, 1); ea("ori_regdst", F_REGDST, 0);
    check();

    // R-type with unknown funct: illegal in EXEC_R, no writeback
    tick(); drive_a(OP_RTYPE, 6'h27, 1'b1);
    ea("nor_fetch", F_STATE, S_FETCH);
    check();
    tick();
    ea("nor_dec", F_STATE, S_DECODE);
    check();
    tick();
    ea("nor_exec", F_STATE, S_EXEC_R); ea("nor_ill", F_ILL, 1); ea("nor_regw", F_REGW, 0);
    check();
    tick();
    ea("nor_next", F_STATE, S_FETCH);
    check();

    // SW stalled in MEMWR, then reset mid-access
    drive_a(OP_SW, 6'h00, 1'b1);
    tick();
    ea("sw_dec", F_STATE, S_DECODE);
    check();
    tick(); ifa.mem_ready = 1'b0;
    ea("sw_adr", F_STATE, S_MEMADR);
    check();
    tick();
    ea("sw_wr", F_STATE, S_MEMWR); ea("sw_mwr", F_MWR, 1); ea("sw_iord", F_IORD, 1);
    check();
    tick(); rst_n = 1'b0;
    ea("sw_rst_st", F_STATE, S_FETCH); ea("sw_rst_mwr", F_MWR, 0); ea("sw_rst_to", F_TO, 0);
    ea("sw_rst_ill", F_ILL, 0);
    check();
    tick(); rst_n = 1'b1;
    ea("post_rst_st", F_STATE, S_FETCH); ea("post_rst_mrd", F_MRD, 1); ea("post_rst_mwr", F_MWR, 0);
    ea("post_rst_pcw", F_PCW, 0); ea("post_rst_irw", F_IRW, 0); ea("post_rst_regw", F_REGW, 0);
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 3: alu_control width, minimum 3.
REQ-002 SHALL have parameter TO_W, default 4: memory-wait timeout counter width; limit = 2^TO_W-1 cycles.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports opcode and funct, input, 6 each: instruction fields from IR.
REQ-006 SHALL have port mem_ready, input, 1: memory access completes this cycle.
REQ-007 SHALL have these 1-bit outputs: pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a, reg_write, branch, branch_ne, imm_zext.
REQ-008 SHALL have these 2-bit outputs: pc_src (0 alu, 1 alu_out, 2 jump target), alu_src_b, reg_dst (0 rt, 1 rd, 2 r31), mem_to_reg (0 alu_out, 1 mem data, 2 PC).
REQ-009 SHALL have output alu_control, ALU_CTRL_W: ALU op, 3-bit code zero-extended.
REQ-010 SHALL have outputs illegal and timeout, 1 each: one-cycle error pulses.
REQ-011 SHALL have output state_o, 4: current state for debug.

Function
REQ-012 SHALL be a Moore FSM; every control output is a function of the state register and mem_ready only.
REQ-013 SHALL use states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, JAL.
REQ-014 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, ADD.
- While mem_ready=0: hold.
- Cycle with mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
REQ-015 DECODE SHALL compute branch target (alu_src_a=0, alu_src_b=3, ADD) and dispatch on opcode:
- 0x23/0x2B -> MEMADR
- 0x00 -> EXEC_R
- 0x08/0x0C/0x0D/0x0A -> EXEC_I
- 0x04/0x05 -> BRANCH
- 0x02 -> JUMP
- else: illegal=1, go to FETCH.
REQ-016 MEMADR SHALL compute rs+signext(imm); then LW -> MEMRD, SW -> MEMWR.
REQ-017 MEMRD SHALL drive mem_read=1, i_or_d=1, hold until mem_ready, then go to MEMWB.
REQ-018 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-019 MEMWR SHALL drive mem_write=1, i_or_d=1, hold until mem_ready, then go to FETCH.
REQ-020 EXEC_R SHALL take alu_control from funct: 0x20 ADD(010), 0x22 SUB(110), 0x24 AND(000), 0x25 OR(001), 0x2A SLT(111).
- Any other funct: illegal=1, go to FETCH, no write.
REQ-021 EXEC_I SHALL use alu_src_b=2 with these ops: ADDI ADD, ANDI AND with imm_zext=1, ORI OR with imm_zext=1, SLTI SLT.
REQ-022 ALUWB SHALL drive reg_write=1, mem_to_reg=0, reg_dst=1 after EXEC_R and 0 after EXEC_I, then go to FETCH.
REQ-023 BRANCH SHALL drive SUB, pc_src=1, branch=1, branch_ne=(opcode==0x05), then go to FETCH.
REQ-024 JUMP SHALL drive pc_write=1, pc_src=2, then go to FETCH.
REQ-025 Wait-state timeout SHALL behave as follows:
- Counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle mem_ready=0 there.
- On reaching 2^TO_W-1 with mem_ready still 0: timeout=1, no write strobes, go to FETCH.
REQ-026 mem_ready asserted outside FETCH/MEMRD/MEMWR SHALL be ignored.
REQ-027 Unused/unreachable state encodings SHALL drive all strobes 0 and go to FETCH next cycle.

Reset
REQ-028 rst_n low SHALL immediately force state FETCH, zero the timeout counter, and clear illegal/timeout, including mid-access.
REQ-029 The first cycle after reset release SHALL be FETCH with mem_read=1 and all write strobes 0.

Configuration
REQ-030 With MC_JAL_EN defined, opcode 0x03 in DECODE SHALL go to JAL, which does the following in one cycle:
- pc_write=1, pc_src=2
- reg_write=1, reg_dst=2, mem_to_reg=2
- then go to FETCH.
REQ-031 Without MC_JAL_EN, opcode 0x03 SHALL be illegal; the JAL state and mem_to_reg=2 SHALL not exist.

Structure
REQ-032 Package mc_pkg SHALL hold the opcode/funct constants, state encodings and 3-bit ALU codes.
REQ-033 Sub-module mc_alu_decoder SHALL map state class plus opcode/funct to alu_control and the funct-illegal flag.

Verification
REQ-034 ADD (opcode 0x00, funct 0x20) with mem_ready tied 1:
- FETCH, DECODE, EXEC_R, ALUWB, FETCH.
- alu_control=010; reg_write in ALUWB only, reg_dst=1.
REQ-035 LW with mem_ready low 3 cycles in MEMRD:
- MEMRD held 4 cycles, then MEMWB with reg_write=1, mem_to_reg=1.
REQ-036 TO_W=2, FETCH with mem_ready=0 for 3 cycles:
- timeout pulses once, ir_write never 1, state stays/returns FETCH.
REQ-037 BNE (0x05):
- BRANCH with branch=1, branch_ne=1, alu_control=110.
- Opcode 0x3F: illegal pulse in DECODE, next FETCH.
REQ-038 Opcode 0x03 in both builds:
- With MC_JAL_EN: JAL, reg_dst=2, mem_to_reg=2, pc_src=2.
- Without MC_JAL_EN: illegal=1.
REQ-039 rst_n dropped mid-MEMWR:
- mem_write drops immediately; state_o=FETCH during reset; FETCH first cycle after release.
